// File: rtl/pin_bus_pkg.sv
// Shared constants, bus word type and width helper for the pin bus sampler.
package pin_bus_pkg;

    localparam int DEF_WIDTH       = 4;
    localparam int DEF_SYNC_STAGES = 2;
    localparam int DEF_STABLE_CNT  = 3;
    localparam int DEF_FIFO_DEPTH  = 4;

    typedef logic [DEF_WIDTH-1:0] word_t;

    // Bits needed to hold values 0..max_val; never less than one bit.
    function automatic int cnt_w(input int max_val);
        return (max_val < 2) ? 1 : $clog2(max_val + 1);
    endfunction

endpackage

// File: rtl/pin_bus_sampler_if.sv
// Valid/ready event stream carrying qualified bus words to the controller.
interface pin_bus_sampler_if
    import pin_bus_pkg::*;
#(
    parameter int WIDTH = DEF_WIDTH
);

    logic [WIDTH-1:0] out_data;
    logic             out_valid;
    logic             out_ready;

    modport master (output out_data, output out_valid, input out_ready);
    modport slave  (input out_data, input out_valid, output out_ready);

endinterface

// File: rtl/pin_bus_fifo.sv
// First-word-fall-through event FIFO; head word is driven straight from storage.
module pin_bus_fifo
    import pin_bus_pkg::*;
#(
    parameter int WIDTH = DEF_WIDTH,
    parameter int DEPTH = DEF_FIFO_DEPTH
) (
    input  logic                       clk,
    input  logic                       rstb,
    input  logic                       push,
    input  logic                       pop,
    input  logic [WIDTH-1:0]           din,
    output logic [WIDTH-1:0]           dout,
    output logic                       full,
    output logic                       empty,
    output logic [cnt_w(DEPTH)-1:0]    level
);

    localparam int PW = cnt_w(DEPTH - 1);
    localparam int LW = cnt_w(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PW-1:0]    wr_ptr;
    logic [PW-1:0]    rd_ptr;
    logic             pop_ok;
    logic             push_ok;

    assign full    = (level == LW'(DEPTH));
    assign empty   = (level == '0);
    assign pop_ok  = pop && !empty;
    // A pop on the same edge frees the slot, so a full FIFO still accepts.
    assign push_ok = push && (!full || pop_ok);
    assign dout    = mem[rd_ptr];

    always_ff @(posedge clk or negedge rstb) begin
        if (!rstb) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem[i] <= '0;
            end
            wr_ptr <= '0;
            rd_ptr <= '0;
            level  <= '0;
        end else begin
            if (push_ok) begin
                mem[wr_ptr] <= din;
                wr_ptr      <= wr_ptr + 1'b1;
            end
            if (pop_ok) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            if (push_ok && !pop_ok) begin
                level <= level + 1'b1;
            end else if (!push_ok && pop_ok) begin
                level <= level - 1'b1;
            end
        end
    end

endmodule

// File: rtl/pin_bus_sampler.sv
// Synchronizes the lane array bus, filters glitches by word stability and
// queues every qualified word change for the controller.
module pin_bus_sampler
    import pin_bus_pkg::*;
#(
    parameter int WIDTH       = DEF_WIDTH,
    parameter int SYNC_STAGES = DEF_SYNC_STAGES,
    parameter int STABLE_CNT  = DEF_STABLE_CNT,
    parameter int FIFO_DEPTH  = DEF_FIFO_DEPTH
) (
    input  logic                          clk,
    input  logic                          rstb,
    input  logic [WIDTH-1:0]              mid,
    input  logic                          en,
    output logic [WIDTH-1:0]              filt_val,
    output logic [cnt_w(FIFO_DEPTH)-1:0]  level,
    output logic                          overflow,
    input  logic                          clr_ovf,
    pin_bus_sampler_if.master             ob
);

    localparam int CW = cnt_w(STABLE_CNT);
    localparam logic [CW-1:0] STABLE_C = CW'(STABLE_CNT);

    logic [WIDTH-1:0] sync_q [SYNC_STAGES];
    logic [WIDTH-1:0] sync;
    logic [WIDTH-1:0] candidate;
    logic [CW-1:0]    cnt;
    logic             evt;
    logic             push;
    logic             pop;
    logic             drop;
    logic             fifo_full;
    logic             fifo_empty;
    logic [WIDTH-1:0] fifo_dout;

    always_ff @(posedge clk or negedge rstb) begin
        if (!rstb) begin
            for (int i = 0; i < SYNC_STAGES; i++) begin
                sync_q[i] <= '0;
            end
        end else begin
            sync_q[0] <= mid;
            for (int i = 1; i < SYNC_STAGES; i++) begin
                sync_q[i] <= sync_q[i-1];
            end
        end
    end

    assign sync = sync_q[SYNC_STAGES-1];

    // Qualification looks only at registered filter state, never at sync.
    assign evt  = (cnt == STABLE_C) && (candidate != filt_val);
    assign push = evt && en;
    assign pop  = ob.out_valid && ob.out_ready;
    assign drop = push && fifo_full && !pop;

    always_ff @(posedge clk or negedge rstb) begin
        if (!rstb) begin
            candidate <= '0;
            cnt       <= '0;
            filt_val  <= '0;
            overflow  <= 1'b0;
        end else begin
            if (sync != candidate) begin
                candidate <= sync;
                cnt       <= CW'(1);
            end else if (cnt < STABLE_C) begin
                cnt <= cnt + 1'b1;
            end
            if (evt) begin
                filt_val <= candidate;
            end
            if (drop) begin
                overflow <= 1'b1;
            end else if (clr_ovf) begin
                overflow <= 1'b0;
            end
        end
    end

    pin_bus_fifo #(
        .WIDTH (WIDTH),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk   (clk),
        .rstb  (rstb),
        .push  (push),
        .pop   (pop),
        .din   (candidate),
        .dout  (fifo_dout),
        .full  (fifo_full),
        .empty (fifo_empty),
        .level (level)
    );

    assign ob.out_valid = !fifo_empty;
    assign ob.out_data  = fifo_dout;

endmodule

// File: tb/tb_pin_bus_sampler.sv
// Directed and randomized bench for pin_bus_sampler against a sample-history
// and queue model of the filter and event FIFO.
module tb_pin_bus_sampler;
    import pin_bus_pkg::*;

    localparam int DEPTH = DEF_FIFO_DEPTH;
    localparam int DLY   = DEF_SYNC_STAGES + 1;
    localparam int HL    = DLY + DEF_STABLE_CNT;

    logic  clk  = 1'b0;
    logic  rstb = 1'b0;
    word_t mid  = '0;
    logic  en   = 1'b1;
    logic  rdy  = 1'b0;
    logic  clr  = 1'b0;
    word_t filt_val;
    logic [2:0] level;
    logic  overflow;

    pin_bus_sampler_if #(.WIDTH(DEF_WIDTH)) ob();
    assign ob.out_ready = rdy;

    pin_bus_sampler dut (
        .clk      (clk),
        .rstb     (rstb),
        .mid      (mid),
        .en       (en),
        .filt_val (filt_val),
        .level    (level),
        .overflow (overflow),
        .clr_ovf  (clr),
        .ob       (ob.master)
    );

    always #5 clk = ~clk;

    int    vectors    = 0;
    int    miscompares = 0;
    word_t sh [HL];
    word_t mq [$];
    word_t m_filt;
    logic  m_ovf;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        for (int k = 0; k < HL; k++) sh[k] = '0;
        mq.delete();
        m_filt = '0;
        m_ovf  = 1'b0;
    endtask

    // sh[k] is the word sampled k edges ago; a word is accepted once it was
    // sampled STABLE_CNT times in a row, seen through the synchronizer delay.
    task automatic model_edge();
        logic  evt, pop, push, drop;
        word_t w;
        for (int k = HL - 1; k > 0; k--) sh[k] = sh[k-1];
        sh[0] = mid;
        w   = sh[DLY];
        evt = (w != m_filt);
        for (int k = DLY + 1; k < HL; k++) if (sh[k] != w) evt = 1'b0;
        pop  = (mq.size() > 0) && rdy;
        push = evt && en;
        drop = push && (mq.size() == DEPTH) && !pop;
        if (pop) void'(mq.pop_front());
        if (push && !drop) mq.push_back(w);
        if (evt) m_filt = w;
        if (drop) m_ovf = 1'b1;
        else if (clr) m_ovf = 1'b0;
    endtask

    task automatic check_all();
        chk("filt_val", 32'(filt_val), 32'(m_filt));
        chk("out_valid", 32'(ob.out_valid), 32'(mq.size() != 0));
        chk("level", 32'(level), 32'(mq.size()));
        chk("overflow", 32'(overflow), 32'(m_ovf));
        if (mq.size() != 0) chk("out_data", 32'(ob.out_data), 32'(mq[0]));
    endtask

    task automatic cycle();
        @(posedge clk);
        model_edge();
        @(negedge clk);
        check_all();
    endtask

    task automatic hold(input word_t v, input int n);
        mid = v;
        repeat (n) cycle();
    endtask

    task automatic reset_check(input string tag);
        chk({tag, "_filt"}, 32'(filt_val), 32'h0);
        chk({tag, "_valid"}, 32'(ob.out_valid), 32'h0);
        chk({tag, "_level"}, 32'(level), 32'h0);
        chk({tag, "_ovf"}, 32'(overflow), 32'h0);
        chk({tag, "_data"}, 32'(ob.out_data), 32'h0);
    endtask

    initial begin
        int hold_left;
        model_reset();
        repeat (2) @(posedge clk);
        @(negedge clk);
        reset_check("rst");
        rstb = 1'b1;
        hold(4'h0, 8);
        reset_check("idle");

        // Latency of a clean change 0 -> A
        mid = 4'hA;
        repeat (5) cycle();
        chk("lat_pre", 32'(filt_val), 32'h0);
        cycle();
        chk("lat_hit", 32'(filt_val), 32'hA);
        chk("lat_level", 32'(level), 32'h1);
        chk("lat_data", 32'(ob.out_data), 32'hA);
        hold(4'hA, 4);
        rdy = 1'b1; cycle(); rdy = 1'b0;

        // Short glitch rejected, exactly-STABLE_CNT pulse accepted
        hold(4'h5, 2);
        hold(4'hA, 8);
        chk("glitch_filt", 32'(filt_val), 32'hA);
        chk("glitch_level", 32'(level), 32'h0);
        hold(4'h5, 3);
        hold(4'hA, 8);
        chk("pulse_level", 32'(level), 32'h2);
        chk("pulse_head", 32'(ob.out_data), 32'h5);
        rdy = 1'b1; hold(4'hA, 2); rdy = 1'b0;

        // Overflow on a full FIFO, ordered drain, sticky clear
        for (int v = 1; v <= 5; v++) hold(word_t'(v), 7);
        chk("ovf_level", 32'(level), 32'h4);
        chk("ovf_set", 32'(overflow), 32'h1);
        rdy = 1'b1;
        for (int v = 1; v <= 4; v++) begin
            chk("drain_order", 32'(ob.out_data), 32'(v));
            cycle();
        end
        chk("drain_empty", 32'(ob.out_valid), 32'h0);
        rdy = 1'b0;
        clr = 1'b1; cycle(); clr = 1'b0;
        chk("ovf_clr", 32'(overflow), 32'h0);

        // Push and pop on the same edge while full
        hold(4'h6, 7); hold(4'h8, 7); hold(4'h9, 7); hold(4'hB, 7);
        mid = 4'hC;
        repeat (5) cycle();
        rdy = 1'b1; cycle(); rdy = 1'b0;
        chk("fullpp_level", 32'(level), 32'h4);
        chk("fullpp_ovf", 32'(overflow), 32'h0);
        rdy = 1'b1;
        repeat (3) cycle();
        chk("fullpp_last", 32'(ob.out_data), 32'hC);
        cycle();
        chk("fullpp_empty", 32'(ob.out_valid), 32'h0);
        rdy = 1'b0;

        // Disabled capture
        en = 1'b0;
        hold(4'h7, 8);
        chk("en0_filt", 32'(filt_val), 32'h7);
        chk("en0_level", 32'(level), 32'h0);
        en = 1'b1;

        // Reset with entries queued
        hold(4'h1, 7); hold(4'h2, 7); hold(4'h4, 7);
        chk("pre_rst_level", 32'(level), 32'h3);
        mid  = 4'h3;
        rstb = 1'b0;
        #1;
        reset_check("midrst");
        model_reset();
        repeat (2) @(posedge clk);
        @(negedge clk);
        rstb = 1'b1;
        repeat (5) cycle();
        chk("rel_pre_level", 32'(level), 32'h0);
        cycle();
        chk("rel_filt", 32'(filt_val), 32'h3);
        chk("rel_level", 32'(level), 32'h1);
        chk("rel_data", 32'(ob.out_data), 32'h3);

        // Randomized traffic against the model
        hold_left = 0;
        for (int i = 0; i < 600; i++) begin
            if (hold_left == 0) begin
                mid       = word_t'($urandom_range(0, 15));
                hold_left = $urandom_range(1, 6);
            end
            hold_left--;
            rdy = ((i / 40) % 2 == 0) ? ($urandom_range(0, 3) == 0) : ($urandom_range(0, 3) != 0);
            en  = ($urandom_range(0, 7) != 0);
            clr = ($urandom_range(0, 15) == 0);
            cycle();
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
